sic1_out_uart: RTL and testbench

//  Consumer end of the SIC1 output port: captures each byte the CPU writes to address 254
//  (uo_out/out_strobe) into a small FIFO and serialises it as 8N1 UART on tx.

---
 rtl/sic1_pkg.sv | 16 +
 rtl/sic1_out_uart_if.sv | 10 +
 rtl/sic1_byte_fifo.sv | 52 +++++
 rtl/sic1_out_uart.sv | 142 ++++++++++++++
 tb/tb_sic1_out_uart.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/sic1_pkg.sv
// Shared definitions for the SIC1 I/O blocks: UART transmitter states and
// the memory-mapped addresses of the CPU I/O ports.
package sic1_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam logic [7:0] ADDR_OUT       = 8'd254;
    localparam logic [7:0] ADDR_IN        = 8'd253;
    localparam int         UART_DATA_BITS = 8;

endpackage

// File: rtl/sic1_out_uart_if.sv
// Byte stream from the SIC1 output port (uo_out plus its write strobe).
interface sic1_out_uart_if;

    logic [7:0] out_byte;
    logic       out_strobe;

    modport master (output out_byte, output out_strobe);
    modport slave  (input  out_byte, input  out_strobe);

endinterface

// File: rtl/sic1_byte_fifo.sv
// Synchronous byte FIFO; dout is the head entry and is valid while !empty.
// The caller must not push while full unless it also pops on that edge.
module sic1_byte_fifo #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_q;

    // NOTE: the storage array is deliberately not reset; only pointers and level are.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // NOTE: sequential state is always updated with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Occupancy decides full/empty so wrapped pointers never need disambiguating.
    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign dout  = mem[rd_ptr];

endmodule

// File: rtl/sic1_out_uart.sv
// SIC1 output port consumer: buffers CPU-written bytes and sends them as
// back-to-back 8N1 UART frames on tx, flagging dropped bytes in overflow.
module sic1_out_uart
    import sic1_pkg::*;
#(
    parameter  int CLKS_PER_BIT = 16,
    parameter  int FIFO_DEPTH   = 4,
    localparam int LW           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    sic1_out_uart_if.slave          out_port,
    input  logic                    clr_overflow,
    output logic                    tx,
    output logic                    busy,
    output logic                    overflow,
    output logic [LW-1:0]           fifo_level
);

    localparam int            TW         = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT   = 3'(UART_DATA_BITS - 1);

    uart_state_t   state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [2:0]    bit_cnt, bit_cnt_nxt;
    logic [7:0]    shift_reg, shift_nxt;
    logic          tx_q, tx_nxt;
    logic          overflow_q;

    logic          fifo_push, fifo_pop, fifo_full, fifo_empty, drop;
    logic [7:0]    fifo_dout;
    logic          bit_end;

    // A full FIFO still accepts a byte when the transmitter frees a slot on the same edge.
    assign fifo_push = out_port.out_strobe & (~fifo_full | fifo_pop);
    assign drop      = out_port.out_strobe & ~fifo_push;
    assign bit_end   = (timer == '0);

    sic1_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (out_port.out_byte),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            tx_q      <= 1'b1;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shift_reg <= shift_nxt;
            tx_q      <= tx_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift_reg;
        tx_nxt      = tx_q;
        fifo_pop    = 1'b0;

        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_nxt = fifo_dout;
                    timer_nxt = TIMER_LOAD;
                    tx_nxt    = 1'b0;
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_end) begin
                    timer_nxt   = TIMER_LOAD;
                    bit_cnt_nxt = '0;
                    tx_nxt      = shift_reg[0];
                    state_nxt   = DATA;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    timer_nxt = TIMER_LOAD;
                    if (bit_cnt == LAST_BIT) begin
                        tx_nxt    = 1'b1;
                        state_nxt = STOP;
                    end else begin
                        shift_nxt   = {1'b0, shift_reg[7:1]};
                        tx_nxt      = shift_reg[1];
                        bit_cnt_nxt = bit_cnt + 3'd1;
                    end
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    // Chain straight into the next start bit when more bytes wait.
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        shift_nxt = fifo_dout;
                        timer_nxt = TIMER_LOAD;
                        tx_nxt    = 1'b0;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)            overflow_q <= 1'b0;
        else if (drop)         overflow_q <= 1'b1;
        else if (clr_overflow) overflow_q <= 1'b0;
    end

    assign tx       = tx_q;
    assign overflow = overflow_q;
    assign busy     = (state != IDLE) | (fifo_level != '0);

endmodule

// File: tb/tb_sic1_out_uart.sv
// Randomised bench for sic1_out_uart: a frame-level reference model predicts
// status each cycle, and a UART decoder checks transmitted bytes against a scoreboard.
module tb_sic1_out_uart;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int FRAME = 10 * CPB;

    logic          clk;
    logic          rst_n;
    logic          clr_overflow;
    logic          tx;
    logic          busy;
    logic          overflow;
    logic [LW-1:0] fifo_level;

    sic1_out_uart_if out_if ();

    sic1_out_uart #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .out_port     (out_if),
        .clr_overflow (clr_overflow),
        .tx           (tx),
        .busy         (busy),
        .overflow     (overflow),
        .fifo_level   (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: queued bytes, cycles left in the current frame, its byte.
    logic [7:0] model_q [$];
    logic [7:0] sb      [$];
    logic [7:0] cur_byte = 8'h00;
    int         remain   = 0;
    logic       m_ovf    = 1'b0;
    bit         rst_applied = 1'b0;

    bit         mon_active = 1'b0;
    int         mon_cnt    = 0;
    logic [7:0] mon_byte   = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Line level implied by the position inside a 10-bit frame.
    function automatic logic exp_tx();
        int p;
        if (remain == 0) return 1'b1;
        p = (FRAME - remain) / CPB;
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return cur_byte[p-1];
    endfunction

    task automatic step(input logic s, input logic [7:0] b, input logic c, input logic r);
        logic pop, acc;
        out_if.out_strobe = s;
        out_if.out_byte   = b;
        clr_overflow      = c;
        rst_n             = ~r;
        if (r) begin
            model_q.delete();
            sb.delete();
            remain      = 0;
            m_ovf       = 1'b0;
            rst_applied = 1'b1;
        end else begin
            pop = (model_q.size() != 0) && (remain <= 1);
            acc = s && ((model_q.size() < DEPTH) || pop);
            if (pop) begin
                cur_byte = model_q.pop_front();
                remain   = FRAME;
            end else if (remain > 0) begin
                remain--;
            end
            if (acc) begin
                model_q.push_back(b);
                sb.push_back(b);
            end
            if (s && !acc) m_ovf = 1'b1;
            else if (c)    m_ovf = 1'b0;
        end
        @(posedge clk);
        #1;
        check("tx", tx, exp_tx());
        check("busy", busy, (remain != 0) || (model_q.size() != 0));
        check("overflow", overflow, m_ovf);
        check("fifo_level", fifo_level, model_q.size());
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Monitor: decodes 8N1 frames from tx, sampling mid-bit, and pops the scoreboard.
    initial begin
        int idx;
        forever begin
            @(posedge clk);
            #2;
            if (rst_applied) begin
                rst_applied = 1'b0;
                mon_active  = 1'b0;
            end else if (!mon_active) begin
                if (tx === 1'b0) begin
                    mon_active = 1'b1;
                    mon_cnt    = 0;
                end
            end else begin
                mon_cnt++;
                if (mon_cnt % CPB == CPB / 2) begin
                    idx = mon_cnt / CPB;
                    if (idx == 0) begin
                        check("frame_start_bit", tx, 1'b0);
                    end else if (idx <= 8) begin
                        mon_byte[idx-1] = tx;
                    end else begin
                        check("frame_stop_bit", tx, 1'b1);
                        check("frame_expected", sb.size() != 0, 1'b1);
                        if (sb.size() != 0) check("frame_byte", mon_byte, sb.pop_front());
                    end
                end
                if (mon_cnt == FRAME - 1) mon_active = 1'b0;
            end
        end
    end

    initial begin
        int guard;
        out_if.out_strobe = 1'b0;
        out_if.out_byte   = 8'h00;
        clr_overflow      = 1'b0;
        rst_n             = 1'b0;
        @(negedge clk);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        idle(3);

        // Single byte frame.
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        idle(50);

        // Four back-to-back frames.
        for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        idle(4 * FRAME + 10);

        // Six strobes: one dropped, then overflow cleared.
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        idle(5);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        idle(5 * FRAME + 10);

        // Reset in the middle of data bit 3 with two bytes still queued.
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        while (remain > 22) idle(1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        idle(60);

        // Drop and clear on the same edge keeps overflow set.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        step(1'b1, 8'h35, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Full FIFO: strobe on the edge where the stop bit ends and pops.
        guard = 0;
        while (remain != 1 && guard < 2 * FRAME) begin
            idle(1);
            guard++;
        end
        check("stop_pop_alignment", remain, 1);
        step(1'b1, 8'h36, 1'b0, 1'b0);
        idle(5 * FRAME + 10);

        // Random traffic with occasional clears and resets.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 8) == 0, 8'($urandom), ($urandom % 50) == 0, ($urandom % 1500) == 0);
        end

        guard = 0;
        while ((remain != 0 || model_q.size() != 0) && guard < 10 * FRAME) begin
            idle(1);
            guard++;
        end
        idle(5);
        check("drain_done", (remain == 0) && (model_q.size() == 0), 1'b1);
        check("scoreboard_empty", sb.size(), 0);
        check("decoder_idle", mon_active, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
